// File: rtl/idct_pkg.sv
// Shared constants and FSM state encoding for the sequential 8-point IDCT sequencer.
package idct_pkg;

    localparam int unsigned IDCT_N        = 8;
    localparam int unsigned IDCT_IDX_W    = 3;
    localparam int unsigned IDCT_FRAC_IN  = 4;
    localparam int unsigned IDCT_FRAC_OUT = 24;

    localparam int IDCT_PIX_MAX = 127;
    localparam int IDCT_PIX_MIN = -128;

    typedef logic [1:0] idct_state_t;

    localparam idct_state_t ST_LOAD = 2'd0;
    localparam idct_state_t ST_RUN  = 2'd1;
    localparam idct_state_t ST_CAPT = 2'd2;
    localparam idct_state_t ST_SEND = 2'd3;

endpackage

// File: rtl/idct_out_buf.sv
// Result capture buffer and index mux for the IDCT sequencer.
// IDCT_SEQ_PIX_EN adds a round-half-up / saturate-to-pixel output stage.
module idct_out_buf
    import idct_pkg::*;
#(
    parameter int unsigned RES_W  = 39,
    parameter int unsigned DOUT_W = 39
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       i_capt,
    input  logic [IDCT_N*RES_W-1:0]    i_res,
    input  logic [IDCT_IDX_W-1:0]      i_idx,
    output logic [DOUT_W-1:0]          o_data
);

    logic [RES_W-1:0]        r_buf [IDCT_N];
    logic signed [RES_W-1:0] w_sel;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < IDCT_N; i++) r_buf[i] <= '0;
        end else if (i_capt) begin
            for (int i = 0; i < IDCT_N; i++) r_buf[i] <= i_res[i*RES_W +: RES_W];
        end
    end

    assign w_sel = r_buf[i_idx];

`ifdef IDCT_SEQ_PIX_EN
    localparam logic signed [RES_W:0] ROUND_HALF = (RES_W+1)'(64'd1 << (IDCT_FRAC_OUT - 1));

    logic signed [RES_W:0] w_rnd;
    logic signed [RES_W:0] w_shr;
    logic signed [7:0]     w_pix;

    // One guard bit so adding the rounding constant cannot overflow.
    assign w_rnd = {w_sel[RES_W-1], w_sel} + ROUND_HALF;
    assign w_shr = w_rnd >>> IDCT_FRAC_OUT;

    always_comb begin
        w_pix = w_shr[7:0];
        if (w_shr > (RES_W+1)'(IDCT_PIX_MAX)) begin
            w_pix = 8'(IDCT_PIX_MAX);
        end else if (w_shr < (RES_W+1)'(IDCT_PIX_MIN)) begin
            w_pix = 8'(IDCT_PIX_MIN);
        end
    end

    assign o_data = DOUT_W'(w_pix);
`else
    assign o_data = DOUT_W'(w_sel);
`endif

endmodule

// File: rtl/idct_seq_ctrl.sv
// Sequencer for the 8-point sequential 1D-IDCT datapath: load, compute, capture, serialize.
// Optional pixel output (round + saturate) when IDCT_SEQ_PIX_EN is defined.
module idct_seq_ctrl
    import idct_pkg::*;
#(
    parameter int unsigned DIN_W  = 8,
    parameter int unsigned RES_W  = 39,
    parameter int unsigned DOUT_W = 39,
    parameter int unsigned LAT    = 8
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DIN_W-1:0]         s_data,
    input  logic                     s_last,
    output logic [IDCT_N-1:0]        dp_load,
    output logic [DIN_W-1:0]         dp_din,
    output logic                     dp_enable,
    output logic                     dp_out,
    input  logic [IDCT_N*RES_W-1:0]  dp_res,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DOUT_W-1:0]        m_data,
    output logic [IDCT_IDX_W-1:0]    m_idx,
    output logic                     m_last,
    output logic                     busy,
    output logic                     err,
    output logic                     err_sticky,
    input  logic                     err_clr
);

    idct_state_t           r_state;
    logic [IDCT_IDX_W-1:0] r_cnt;
    logic [IDCT_IDX_W-1:0] r_idx;
    logic [7:0]            r_lat;
    logic                  r_err;
    logic                  r_err_sticky;

    logic                  w_acc;
    logic                  w_cnt_last;
    logic                  w_frm_err;
    logic                  w_m_hs;
    logic                  w_lat_done;
    logic [DOUT_W-1:0]     w_buf_data;

    assign s_ready    = (r_state == ST_LOAD);
    assign busy       = (r_state != ST_LOAD);
    assign w_acc      = s_valid & s_ready;
    assign w_cnt_last = (r_cnt == IDCT_IDX_W'(IDCT_N - 1));
    // Last flag must coincide exactly with the 8th beat.
    assign w_frm_err  = w_acc & (s_last != w_cnt_last);
    assign w_lat_done = (r_lat == 8'(LAT - 1));

    assign dp_load   = w_acc ? (IDCT_N'(1) << r_cnt) : '0;
    assign dp_din    = s_data;
    assign dp_enable = (r_state == ST_RUN);
    assign dp_out    = (r_state == ST_CAPT);

    assign m_valid = (r_state == ST_SEND);
    assign w_m_hs  = m_valid & m_ready;
    assign m_idx   = r_idx;
    assign m_last  = m_valid & (r_idx == IDCT_IDX_W'(IDCT_N - 1));
    assign m_data  = m_valid ? w_buf_data : '0;

    assign err        = r_err;
    assign err_sticky = r_err_sticky;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state      <= ST_LOAD;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_lat        <= '0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_err <= w_frm_err;
            if (w_frm_err) begin
                r_err_sticky <= 1'b1;
            end else if (err_clr) begin
                r_err_sticky <= 1'b0;
            end
            case (r_state)
                ST_LOAD: begin
                    if (w_acc) begin
                        if (w_frm_err) begin
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (w_cnt_last) begin
                                r_state <= ST_RUN;
                                r_lat   <= '0;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (w_lat_done) r_state <= ST_CAPT;
                    else            r_lat   <= r_lat + 1'b1;
                end
                ST_CAPT: begin
                    r_state <= ST_SEND;
                    r_idx   <= '0;
                end
                ST_SEND: begin
                    if (w_m_hs) begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == IDCT_IDX_W'(IDCT_N - 1)) r_state <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    idct_out_buf #(
        .RES_W  (RES_W),
        .DOUT_W (DOUT_W)
    ) u_out_buf (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_capt (dp_out),
        .i_res  (dp_res),
        .i_idx  (r_idx),
        .o_data (w_buf_data)
    );

endmodule

// File: tb/tb_idct_seq_ctrl.sv
// Self-checking bench for idct_seq_ctrl: beat table, timing sequences, result scoreboard.
module tb_idct_seq_ctrl;

    localparam int DIN_W  = 8;
    localparam int RES_W  = 39;
    localparam int DOUT_W = 39;
    localparam int LAT    = 8;

    logic                clk = 1'b0;
    logic                clr_n;
    logic                s_valid;
    logic                s_ready;
    logic [DIN_W-1:0]    s_data;
    logic                s_last;
    logic [7:0]          dp_load;
    logic [DIN_W-1:0]    dp_din;
    logic                dp_enable;
    logic                dp_out;
    logic [8*RES_W-1:0]  dp_res;
    logic                m_valid;
    logic                m_ready;
    logic [DOUT_W-1:0]   m_data;
    logic [2:0]          m_idx;
    logic                m_last;
    logic                busy;
    logic                err;
    logic                err_sticky;
    logic                err_clr;

    always #5 clk = ~clk;

    idct_seq_ctrl #(
        .DIN_W  (DIN_W),
        .RES_W  (RES_W),
        .DOUT_W (DOUT_W),
        .LAT    (LAT)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .dp_load    (dp_load),
        .dp_din     (dp_din),
        .dp_enable  (dp_enable),
        .dp_out     (dp_out),
        .dp_res     (dp_res),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_idx      (m_idx),
        .m_last     (m_last),
        .busy       (busy),
        .err        (err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] exp_load;
        logic       exp_err;
    } beat_t;

    typedef struct {
        logic [DOUT_W-1:0] data;
        logic [2:0]        idx;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t sb_e;
    logic              hold_pending = 1'b0;
    logic [DOUT_W-1:0] hold_data;
    logic [2:0]        hold_idx;
    logic [7:0]        coef [8];
    beat_t             vec [11];
    logic [RES_W-1:0]  h [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DOUT_W-1:0] exp_word(input logic [RES_W-1:0] hv);
`ifdef IDCT_SEQ_PIX_EN
        longint v;
        longint q;
        v = longint'(signed'(hv));
        q = (v + 64'sd8388608) >>> 24;
        if (q > 127) q = 127;
        else if (q < -128) q = -128;
        return DOUT_W'(q);
`else
        return DOUT_W'(signed'(hv));
`endif
    endfunction

    task automatic load_res();
        for (int i = 0; i < 8; i++) dp_res[i*RES_W +: RES_W] = h[i];
    endtask

    task automatic push_exp();
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.data = exp_word(dp_res[i*RES_W +: RES_W]);
            e.idx  = 3'(i);
            sb_q.push_back(e);
        end
    endtask

    // Called just after a rising edge; each beat is accepted on the next edge.
    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            s_valid = 1'b1;
            s_data  = coef[i];
            s_last  = (i == 7);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain(input bit toggle, input int budget);
        int n = 0;
        m_ready = ~toggle;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (toggle) m_ready = ~m_ready;
        end
        m_ready = 1'b1;
        chk("drain_timeout", sb_q.size(), 0);
        chk("busy_after_send", busy, 0);
    endtask

    // Output monitor: stability under backpressure plus scoreboard compare.
    always @(negedge clk) begin
        if (!clr_n) begin
            hold_pending <= 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, hold_data);
                chk("hold_idx", m_idx, hold_idx);
            end
            if (m_valid) begin
                if (m_ready) begin
                    chk("sb_avail", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        sb_e = sb_q.pop_front();
                        chk("m_data", m_data, sb_e.data);
                        chk("m_idx", m_idx, sb_e.idx);
                        chk("m_last", m_last, sb_e.idx == 3'd7);
                    end
                end
                hold_pending <= ~m_ready;
                hold_data    <= m_data;
                hold_idx     <= m_idx;
            end else begin
                hold_pending <= 1'b0;
            end
        end
    end

    initial begin
        int stall_bad;
        coef = '{8'h32, 8'h45, 8'h77, 8'hE2, 8'h32, 8'hE2, 8'hF3, 8'h15};
        vec[0] = '{8'h11, 1'b0, 8'h01, 1'b0};
        vec[1] = '{8'h22, 1'b0, 8'h02, 1'b0};
        vec[2] = '{8'h33, 1'b1, 8'h04, 1'b1};
        for (int i = 0; i < 8; i++) vec[3+i] = '{coef[i], i == 7, 8'(1 << i), 1'b0};

        clr_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        m_ready = 1'b0; err_clr = 1'b0; dp_res = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_dp_enable", dp_enable, 0);
        chk("rst_dp_out", dp_out, 0);
        chk("rst_dp_load", dp_load, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_idx", m_idx, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_err_sticky", err_sticky, 0);
        @(posedge clk); #1;
        clr_n = 1'b1;

        // Framing-error block followed by the nominal block, results H_i = i * 2^24.
        for (int i = 0; i < 8; i++) h[i] = RES_W'(64'(i) << 24);
        load_res();
        m_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            s_valid = 1'b1;
            s_data  = vec[k].data;
            s_last  = vec[k].last;
            @(negedge clk);
            chk("tbl_s_ready", s_ready, 1);
            chk("tbl_dp_load", dp_load, vec[k].exp_load);
            chk("tbl_dp_din", dp_din, vec[k].data);
            @(posedge clk); #1;
            chk("tbl_err", err, vec[k].exp_err);
            if (vec[k].last && !vec[k].exp_err) push_exp();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("err_sticky_set", err_sticky, 1);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            chk("run_dp_enable", dp_enable, 1);
            chk("run_dp_out", dp_out, 0);
            chk("run_s_ready", s_ready, 0);
        end
        @(negedge clk);
        chk("capt_dp_enable", dp_enable, 0);
        chk("capt_dp_out", dp_out, 1);
        chk("capt_m_valid", m_valid, 0);
        @(negedge clk);
        chk("send_m_valid", m_valid, 1);
        chk("send_dp_out", dp_out, 0);
        @(posedge clk); #1;
        drain(1'b0, 40);

        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("err_sticky_clr", err_sticky, 0);

        // Backpressure with arbitrary result words.
        for (int i = 0; i < 8; i++) h[i] = RES_W'({$urandom, $urandom});
        load_res();
        send_range(0, 7);
        push_exp();
        drain(1'b1, 80);

        // Stalled input between beats 4 and 5.
        send_range(0, 3);
        stall_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (dp_enable || busy || dp_load != 8'h00) stall_bad++;
        end
        chk("stall_idle", stall_bad, 0);
        @(posedge clk); #1;
        send_range(4, 7);
        push_exp();
        drain(1'b0, 40);

        // Reset in the 3rd enable cycle; pending results are lost.
        send_range(0, 7);
        repeat (3) @(negedge clk);
        chk("pre_rst_dp_enable", dp_enable, 1);
        clr_n = 1'b0;
        #1;
        chk("mid_rst_dp_enable", dp_enable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        chk("mid_rst_m_valid", m_valid, 0);
        @(posedge clk); #1;
        clr_n = 1'b1;

        // Rounding/saturation corners (raw values in the default build).
        h[0] = RES_W'(64'sd25165824);
        h[1] = RES_W'(-64'sd25165824);
        h[2] = RES_W'(64'sd300 << 24);
        h[3] = RES_W'(-(64'sd500 << 24));
        h[4] = RES_W'(64'sd8388608);
        h[5] = RES_W'(-64'sd8388608);
        h[6] = RES_W'(64'sd0);
        h[7] = RES_W'(64'sd100 << 24);
        load_res();
        send_range(0, 7);
        push_exp();
        drain(1'b0, 40);

        chk("sb_empty_end", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idct_seq_ctrl.md
# idct_seq_ctrl

Sequencer for the 8-point sequential 1D-IDCT datapath (`idctsim`). It accepts a framed stream of 8 coefficients over a valid/ready handshake and steers each coefficient into the datapath with one-hot load strobes. It then holds the datapath enable for the compute latency, pulses the output strobe and captures all 8 results. Finally it serializes them on a valid/ready master port, replacing hand-driven `sw`/`enable`/`out` stimulus.

## Interface
- `DIN_W`, 8: coefficient width, signed, 4 fractional bits.
- `RES_W`, 39: datapath result width, signed, 24 fractional bits (H stage).
- `DOUT_W`, 39: `m_data` width; must be >= 9 when `IDCT_SEQ_PIX_EN` is defined.
- `LAT`, 8: datapath enable cycles required per block, 1..255.

- `clk` in 1: clock, rising edge.
- `clr_n` in 1: asynchronous active-low reset.
- `s_valid` in 1: coefficient beat valid.
- `s_ready` out 1: coefficient beat ready.
- `s_data` in DIN_W: coefficient value.
- `s_last` in 1: marks coefficient 7 of the block.
- `dp_load` out 8: one-hot load strobe; bit i loads input Ii.
- `dp_din` out DIN_W: coefficient to the datapath.
- `dp_enable` out 1: datapath compute enable.
- `dp_out` out 1: datapath output strobe.
- `dp_res` in 8*RES_W: results H0..H7, H0 in the LSBs.
- `m_valid` out 1: result beat valid.
- `m_ready` in 1: result beat ready.
- `m_data` out DOUT_W: result value.
- `m_idx` out 3: result index.
- `m_last` out 1: asserted with index 7.
- `busy` out 1: high in any state other than LOAD.
- `err` out 1: one-cycle framing error pulse.
- `err_sticky` out 1: latched framing error.
- `err_clr` in 1: clears `err_sticky`.

## Operation
- FSM states: LOAD (reset state), RUN, CAPT, SEND.
- **LOAD**
  - `s_ready`=1. A beat is accepted when `s_valid`&`s_ready`.
  - On each accepted beat, `dp_load[cnt]`=1 and `dp_din`=`s_data`; both are combinational, so the datapath registers the beat on the same edge. Then `cnt`++.
  - Framing is checked on every accepted beat:
    - `s_last`=1 with `cnt`<7, or `s_last`=0 with `cnt`==7, is an error.
    - On error, the beat is still loaded, then `err` pulses, `err_sticky` sets, `cnt` goes to 0 and the FSM stays in LOAD; the block is discarded.
  - A valid 8th beat leads to RUN.
- **RUN**: `s_ready`=0, `dp_enable`=1 (registered), latency counter counts LAT cycles, then CAPT.
- **CAPT**
  - `dp_out`=1 for exactly one cycle.
  - All 8 `dp_res` words are registered into the output buffer on that cycle's closing edge.
  - Then SEND with `idx`=0.
- **SEND**
  - `m_valid`=1; `m_data`=buf[idx], `m_idx`=idx, `m_last`=(idx==7).
  - On `m_valid`&`m_ready`, `idx`++. The handshake completing at idx 7 returns the FSM to LOAD.
  - The output is held stable while `m_ready`=0.
- Width rule without the macro: `m_data` is buf[idx] sign-extended or truncated to DOUT_W.
- `err_clr` and a framing error in the same cycle: set wins.
- No input is accepted outside LOAD; no overlap between blocks.

## Timing
- Values while `clr_n`=0:
  - `s_ready` 1, `dp_enable` 0, `dp_out` 0, `m_valid` 0, `m_data` 0, `m_idx` 0, `m_last` 0, `busy` 0, `err` 0, `err_sticky` 0.
  - `dp_load`=0 whenever `s_valid`=0.
- Reset asserted mid-block (any state): immediate return to LOAD, `cnt`/`idx`/latency counter cleared, buffer contents don't-care, pending results lost.
- Latency: 8th beat accepted at edge t →
  - `dp_enable` high in cycles t+1..t+LAT;
  - `dp_out` in cycle t+LAT+1;
  - `m_valid` from cycle t+LAT+2.
- Minimum block period with `s_valid`/`m_ready` held high: 8+LAT+1+8 cycles (25 at defaults).
- `s_ready` and `busy` are decoded from the registered state only; there is no combinational path from `m_ready` to `s_ready`.

## Configuration
- Macro `IDCT_SEQ_PIX_EN`.
- **Defined**: `m_data` is the pixel value.
  - Round half-up: add 2^23 to buf[idx], then arithmetic shift right by 24.
  - Saturate to [-128,127] and sign-extend to DOUT_W.
- **Undefined**: `m_data` is the raw fixed-point result (24 fractional bits); no rounding or saturation logic is present.

## Structure
- Package `idct_pkg`:
  - constants `IDCT_N`=8, `IDCT_IDX_W`=3, `IDCT_FRAC_IN`=4, `IDCT_FRAC_OUT`=24;
  - FSM state typedef (LOAD/RUN/CAPT/SEND);
  - pixel clip bounds.
- Sub-module `idct_out_buf`:
  - 8×RES_W capture register plus index mux;
  - contains the `IDCT_SEQ_PIX_EN` round/saturate stage.
- The FSM, beat counter and latency counter stay in `idct_seq_ctrl`.

## Test plan
- Nominal block: send 8 beats 0x32,0x45,0x77,0xE2,0x32,0xE2,0xF3,0x15 with `s_last` on the 8th → `dp_load` one-hot 0x01..0x80 in order, `dp_enable` high exactly 8 cycles, one `dp_out` pulse, then 8 result beats in index order 0..7 with `m_last` only at index 7. With `dp_res` H0..H7 = i·2^24, raw output reads i.
- Backpressure: `m_ready` toggles every cycle → each word held stable until accepted, no loss or duplication, FSM returns to LOAD after idx 7.
- Framing error: `s_last` on beat 3 → `err` pulse, `err_sticky`=1, the next 8 beats form a clean block. `err_clr` → `err_sticky`=0.
- Reset mid-RUN: drop `clr_n` at the 3rd enable cycle → all outputs at reset values, `dp_enable` 0 immediately, a fresh block afterwards completes normally.
- `IDCT_SEQ_PIX_EN`:
  - H0 = 2^24·1.5 → `m_data` 2;
  - H1 = −2^24·1.5 → −1;
  - H2 = 2^24·300 → 127;
  - H3 = −2^24·500 → −128.
- Stalled input: `s_valid` low for 20 cycles between beats 4 and 5 → no enable, `busy`=0, block completes after resumption.
